// File: rtl/ahb_slave_if_pkg.sv
// Shared AHB definitions: bus width defaults and the HTRANS/HRESP encodings
// used by the AHB slave interface.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package ahb_slave_if_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Only NONSEQ and SEQ carry a real address phase.
    function automatic logic is_active_trans(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end: converts AHB transfers into a simple
// valid/ready request to user logic, with two-cycle ERROR responses.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_slave_if
    import ahb_slave_if_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = `AHB_ADDR_WIDTH,
    parameter int AHB_DATA_WIDTH = `AHB_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hsel,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [2:0]                hburst,
    input  logic [AHB_DATA_WIDTH-1:0] hwdata,
    input  logic                      hready,
    output logic                      hreadyout,
    output logic                      hresp,
    output logic [AHB_DATA_WIDTH-1:0] hrdata,
    output logic                      valid,
    output logic [AHB_ADDR_WIDTH-1:0] addr,
    output logic                      write,
    output logic [2:0]                size,
    output logic [AHB_DATA_WIDTH-1:0] wdata,
    input  logic                      ready,
    input  logic [AHB_DATA_WIDTH-1:0] rdata,
    input  logic                      error
);

    localparam int MAX_SIZE = $clog2(AHB_DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      phase;
    logic                      legal;
    logic                      accept;
    logic [AHB_ADDR_WIDTH-1:0] align_mask;
    logic                      unused_hburst;

    // Every beat stands alone, so the burst type carries no information here.
    assign unused_hburst = ^hburst;

    assign phase      = hsel & hready & is_active_trans(htrans);
    assign align_mask = (AHB_ADDR_WIDTH'(1) << hsize) - AHB_ADDR_WIDTH'(1);
    assign legal      = (hsize <= 3'(MAX_SIZE)) && ((haddr & align_mask) == '0);

    // A new address phase can only be taken when no data phase is stalling.
    assign accept = (state == IDLE) || (state == ERR2) ||
                    ((state == ACCESS) && ready && !error);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            write <= 1'b0;
            size  <= 3'd0;
        end else begin
            state <= state_next;
            if (accept && phase && legal) begin
                addr  <= haddr;
                write <= hwrite;
                size  <= hsize;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            if (state == ACCESS && error) begin
                state_next = ERR1;
            end else if (phase) begin
                state_next = legal ? ACCESS : ERR1;
            end else begin
                state_next = IDLE;
            end
        end else if (state == ACCESS) begin
            if (ready && error) begin
                state_next = ERR1;
            end
        end else if (state == ERR1) begin
            state_next = ERR2;
        end
    end

    always_comb begin
        valid     = 1'b0;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        hrdata    = '0;
        case (state)
            ACCESS: begin
                valid     = 1'b1;
                hreadyout = ready & ~error;
                hrdata    = rdata;
            end
            ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            ERR2: begin
                hresp = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    assign wdata = hwdata;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
interface ahb_slave_if_tb #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          valid;
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] rdata;
    logic          error;
endinterface

module tb_ahb_slave_if;
    import ahb_slave_if_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic          hreadyout;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic          other_busy;

    ahb_slave_if_tb #(.AW(AW), .DW(DW)) usr ();

    int checks = 0;
    int errors = 0;

    // Transaction-level model: a pending transfer plus an error countdown.
    bit            m_busy;
    int            m_err_left;
    logic [AW-1:0] m_addr;
    logic          m_write;
    logic [2:0]    m_size;
    bit            exp_hreadyout;

    always #5 clk = ~clk;

    // Another slave may be holding the bus; then HREADY drops for everyone.
    assign hready = hreadyout & ~other_busy;

    ahb_slave_if #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .valid     (usr.valid),
        .addr      (usr.addr),
        .write     (usr.write),
        .size      (usr.size),
        .wdata     (usr.wdata),
        .ready     (usr.ready),
        .rdata     (usr.rdata),
        .error     (usr.error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic bit legal_phase(input logic [AW-1:0] a, input logic [2:0] sz);
        int unsigned bytes;
        bytes = 32'd1 << sz;
        return (bytes <= DW / 8) && ((a % bytes) == 0);
    endfunction

    task automatic apply_stimulus(input logic s, input logic [AW-1:0] a, input logic [1:0] t,
                                  input logic w, input logic [2:0] sz, input logic [DW-1:0] wd,
                                  input logic rdy, input logic [DW-1:0] rd, input logic er);
        hsel      = s;
        haddr     = a;
        htrans    = t;
        hwrite    = w;
        hsize     = sz;
        hwdata    = wd;
        usr.ready = rdy;
        usr.rdata = rd;
        usr.error = er;
    endtask

    task automatic idle_inputs(input logic rdy, input logic [DW-1:0] rd, input logic er);
        apply_stimulus(1'b0, '0, HTRANS_IDLE, 1'b0, 3'd0, '0, rdy, rd, er);
    endtask

    task automatic check_output();
        bit            e_valid;
        bit            e_resp;
        logic [DW-1:0] e_rdata;
        @(negedge clk);
        e_valid = 0;
        e_resp  = 0;
        e_rdata = '0;
        if (m_err_left == 2) begin
            exp_hreadyout = 0;
            e_resp        = 1;
        end else if (m_err_left == 1) begin
            exp_hreadyout = 1;
            e_resp        = 1;
        end else if (m_busy) begin
            e_valid       = 1;
            exp_hreadyout = usr.ready && !usr.error;
            e_rdata       = usr.rdata;
        end else begin
            exp_hreadyout = 1;
        end
        chk("valid", usr.valid, e_valid);
        chk("hreadyout", hreadyout, exp_hreadyout);
        chk("hresp", hresp, e_resp);
        chk("hrdata", hrdata, e_rdata);
        chk("addr", usr.addr, m_addr);
        chk("write", usr.write, m_write);
        chk("size", usr.size, m_size);
        chk("wdata", usr.wdata, hwdata);
    endtask

    task automatic advance();
        bit bus_ready;
        bus_ready = exp_hreadyout && !other_busy;
        if (rst) begin
            m_busy     = 0;
            m_err_left = 0;
            m_addr     = '0;
            m_write    = 0;
            m_size     = '0;
        end else if (m_busy && !usr.ready) begin
            m_busy = 1;
        end else if (m_busy && usr.error) begin
            m_busy     = 0;
            m_err_left = 2;
        end else if (m_err_left == 2) begin
            m_err_left = 1;
        end else begin
            m_busy     = 0;
            m_err_left = 0;
            if (hsel && bus_ready && htrans >= 2'd2) begin
                if (legal_phase(haddr, hsize)) begin
                    m_busy  = 1;
                    m_addr  = haddr;
                    m_write = hwrite;
                    m_size  = hsize;
                end else begin
                    m_err_left = 2;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        check_output();
        advance();
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [2:0]    sz;

        rst        = 1'b1;
        other_busy = 1'b0;
        hburst     = 3'd0;
        idle_inputs(1'b0, '0, 1'b0);
        m_busy     = 0;
        m_err_left = 0;
        m_addr     = '0;
        m_write    = 0;
        m_size     = '0;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        $display("[TB] zero-wait write");
        apply_stimulus(1'b1, 32'h100, HTRANS_NONSEQ, 1'b1, 3'd2, '0, 1'b0, '0, 1'b0);
        step();
        idle_inputs(1'b1, '0, 1'b0);
        hwdata = 32'hDEADBEEF;
        check_output();
        chk("zw_valid", usr.valid, 1);
        chk("zw_addr", usr.addr, 32'h100);
        chk("zw_wdata", usr.wdata, 32'hDEADBEEF);
        chk("zw_hreadyout", hreadyout, 1);
        chk("zw_hresp", hresp, 0);
        advance();

        $display("[TB] waited read");
        apply_stimulus(1'b1, 32'h04, HTRANS_NONSEQ, 1'b0, 3'd2, '0, 1'b0, '0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            idle_inputs(1'b0, '0, 1'b0);
            check_output();
            chk("wait_hreadyout", hreadyout, 0);
            advance();
        end
        idle_inputs(1'b1, 32'h12345678, 1'b0);
        check_output();
        chk("wait_done_hreadyout", hreadyout, 1);
        chk("wait_done_hrdata", hrdata, 32'h12345678);
        advance();
        idle_inputs(1'b0, '0, 1'b0);
        step();

        $display("[TB] user error");
        apply_stimulus(1'b1, 32'h08, HTRANS_NONSEQ, 1'b1, 3'd2, '0, 1'b0, '0, 1'b0);
        step();
        idle_inputs(1'b1, '0, 1'b1);
        check_output();
        chk("uerr_access_hreadyout", hreadyout, 0);
        advance();
        idle_inputs(1'b0, '0, 1'b0);
        check_output();
        chk("uerr_err1_hresp", hresp, 1);
        chk("uerr_err1_hreadyout", hreadyout, 0);
        advance();
        check_output();
        chk("uerr_err2_hresp", hresp, 1);
        chk("uerr_err2_hreadyout", hreadyout, 1);
        advance();
        check_output();
        chk("uerr_idle_hresp", hresp, 0);
        chk("uerr_idle_valid", usr.valid, 0);
        advance();

        $display("[TB] illegal attributes");
        for (int k = 0; k < 2; k++) begin
            a  = (k == 0) ? 32'h0 : 32'h102;
            sz = (k == 0) ? 3'd3 : 3'd2;
            apply_stimulus(1'b1, a, HTRANS_NONSEQ, 1'b0, sz, '0, 1'b0, '0, 1'b0);
            step();
            idle_inputs(1'b1, '0, 1'b0);
            check_output();
            chk("ill_err1_valid", usr.valid, 0);
            chk("ill_err1_hresp", hresp, 1);
            chk("ill_err1_hreadyout", hreadyout, 0);
            advance();
            check_output();
            chk("ill_err2_valid", usr.valid, 0);
            chk("ill_err2_hresp", hresp, 1);
            chk("ill_err2_hreadyout", hreadyout, 1);
            advance();
        end

        $display("[TB] back-to-back burst");
        apply_stimulus(1'b1, 32'h200, HTRANS_NONSEQ, 1'b1, 3'd2, '0, 1'b0, '0, 1'b0);
        step();
        for (int i = 1; i < 4; i++) begin
            apply_stimulus(1'b1, 32'h200 + 32'(4 * i), HTRANS_SEQ, 1'b1, 3'd2,
                           32'(i), 1'b1, '0, 1'b0);
            check_output();
            chk("b2b_valid", usr.valid, 1);
            chk("b2b_addr", usr.addr, 32'h200 + 32'(4 * (i - 1)));
            advance();
        end
        idle_inputs(1'b1, '0, 1'b0);
        check_output();
        chk("b2b_last_valid", usr.valid, 1);
        chk("b2b_last_addr", usr.addr, 32'h20C);
        advance();

        $display("[TB] reset during wait");
        apply_stimulus(1'b1, 32'h10, HTRANS_NONSEQ, 1'b0, 3'd2, '0, 1'b0, '0, 1'b0);
        step();
        idle_inputs(1'b0, '0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output();
        chk("rstw_valid", usr.valid, 0);
        chk("rstw_hreadyout", hreadyout, 1);
        chk("rstw_hresp", hresp, 0);
        advance();

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            apply_stimulus($urandom_range(0, 9) < 8, a, 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), sz, $urandom,
                           $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0);
            hburst     = 3'($urandom_range(0, 7));
            other_busy = ($urandom_range(0, 9) == 0);
            rst        = ($urandom_range(0, 49) == 0);
            step();
        end
        rst        = 1'b0;
        other_busy = 1'b0;
        idle_inputs(1'b1, '0, 1'b0);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
